// File: rtl/spi_led_pkg.sv
// Shared definitions for the SPI LED command controller: parser states,
// register addresses and control-bit positions.
package spi_led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_CHECK = 2'd3
  } parser_state_e;

  // Register addresses (only ADDR values 0..3 are valid; the upper bits are
  // checked separately by the parser).
  localparam logic [1:0] REG_PATTERN = 2'd0;
  localparam logic [1:0] REG_RATE    = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_CLRERR  = 2'd3;

  // Control register bit positions.
  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;

endpackage

// File: rtl/spi_led_cmd_ctrl_seq.sv
// LED pattern sequencer: a power-of-two step divider walks bit_idx through the
// 8-bit pattern LSB first and drives a registered LED output.
module led_pattern_seq
  import spi_led_pkg::*;
#(
  parameter int DIV_WIDTH = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pattern,
  input  logic [4:0] rate,
  input  logic [1:0] ctrl,
  input  logic       restart,
  output logic       led
);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] tick_at;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 led_q, led_d;
  logic                 step_tick;

  // Terminal count is 2^rate - 1; rate is clamped upstream to DIV_WIDTH-1.
  assign tick_at = (DIV_WIDTH'(1) << rate) - DIV_WIDTH'(1);

  // Divider, bit index and LED next-state; restart wins over a step tick.
  always_comb begin
    step_tick = (div_q == tick_at);
    div_d     = step_tick ? '0 : div_q + DIV_WIDTH'(1);
    bit_idx_d = step_tick ? bit_idx_q + 3'd1 : bit_idx_q;
    if (restart) begin
      div_d     = '0;
      bit_idx_d = '0;
    end
    led_d = ctrl[CTRL_EN] ? (pattern[bit_idx_q] ^ ctrl[CTRL_INV]) : ctrl[CTRL_INV];
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      bit_idx_q <= '0;
      led_q     <= 1'b0;
    end else begin
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      led_q     <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/spi_led_cmd_ctrl.sv
// SPI LED command controller: parses SYNC/ADDR/DATA/CHK frames from the SPI
// byte stream into the pattern/rate/ctrl registers, reports frame outcomes,
// counts errors and drives the LED through led_pattern_seq.
//
// Byte interface: byte_in is meaningful only in a cycle where byte_valid=1;
// each such cycle is exactly one byte. There is no back-pressure, so the
// parser consumes every valid byte in the cycle it arrives.
module spi_led_cmd_ctrl
  import spi_led_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 16000,
  parameter int         DIV_WIDTH      = 24,
  parameter int         RATE_RESET     = 20,
  parameter int         ERR_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 led,
  output logic [7:0]           pattern,
  output logic [4:0]           rate,
  output logic [1:0]           ctrl,
  output logic                 busy,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic [ERR_WIDTH-1:0] err_count,
  output parser_state_e        state_dbg
);

  localparam int         TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0] RATE_MAX = 5'(DIV_WIDTH - 1);

  parser_state_e        state_q, state_d;
  logic [7:0]           addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [7:0]           pattern_q, pattern_d;
  logic [4:0]           rate_q, rate_d;
  logic [1:0]           ctrl_q, ctrl_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic                 ok_q, ok_d;
  logic                 ferr_q, ferr_d;
  logic                 restart;
  logic                 timeout;
  logic                 err_inc;

  // Parser next-state, register-file writes, outcome pulses and timeout.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    pattern_d = pattern_q;
    rate_d    = rate_q;
    ctrl_d    = ctrl_q;
    err_d     = err_q;
    ok_d      = 1'b0;
    ferr_d    = 1'b0;
    restart   = 1'b0;
    err_inc   = 1'b0;

    // Idle gap counter; a byte arriving on the final cycle beats the timeout.
    timeout  = (state_q != ST_IDLE) && !byte_valid &&
               (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    to_cnt_d = (state_q == ST_IDLE || byte_valid) ? '0 : to_cnt_q + TO_W'(1);

    if (byte_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_in == SYNC_BYTE) state_d = ST_ADDR;
        end
        ST_ADDR: begin
          addr_d  = byte_in;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          data_d  = byte_in;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          state_d = ST_IDLE;
          if ((byte_in == (SYNC_BYTE ^ addr_q ^ data_q)) && (addr_q[7:2] == 6'd0)) begin
            ok_d = 1'b1;
            case (addr_q[1:0])
              REG_PATTERN: begin
                pattern_d = data_q;
                restart   = 1'b1;
              end
              REG_RATE: begin
                rate_d  = (data_q[4:0] > RATE_MAX) ? RATE_MAX : data_q[4:0];
                restart = 1'b1;
              end
              REG_CTRL:   ctrl_d = data_q[1:0];
              REG_CLRERR: err_d  = '0;
            endcase
          end else begin
            err_inc = 1'b1;
          end
        end
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
      err_inc = 1'b1;
    end

    if (err_inc) begin
      ferr_d = 1'b1;
      if (err_q != '1) err_d = err_q + ERR_WIDTH'(1);
    end
  end

  // Parser state, register file and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      to_cnt_q  <= '0;
      pattern_q <= 8'h00;
      rate_q    <= 5'(RATE_RESET);
      ctrl_q    <= 2'b01;
      err_q     <= '0;
      ok_q      <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      to_cnt_q  <= to_cnt_d;
      pattern_q <= pattern_d;
      rate_q    <= rate_d;
      ctrl_q    <= ctrl_d;
      err_q     <= err_d;
      ok_q      <= ok_d;
      ferr_q    <= ferr_d;
    end
  end

  led_pattern_seq #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .pattern (pattern_q),
    .rate    (rate_q),
    .ctrl    (ctrl_q),
    .restart (restart),
    .led     (led)
  );

  assign pattern   = pattern_q;
  assign rate      = rate_q;
  assign ctrl      = ctrl_q;
  assign busy      = (state_q != ST_IDLE);
  assign frame_ok  = ok_q;
  assign frame_err = ferr_q;
  assign err_count = err_q;
  assign state_dbg = state_q;

endmodule

// File: doc/spi_led_cmd_ctrl.md
Name: spi_led_cmd_ctrl

Overview:
- Command controller between the SPI byte receiver and the user LED.
- Parses framed writes from the received byte stream into a small configuration register file: LED pattern, step rate and control bits.
- Sequences the LED through the 8-bit pattern, LSB first, at the configured rate.
- Reports frame success and failure, and counts errors, so the host can detect corrupted or stalled transfers.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every frame.
- TIMEOUT_CYCLES, 16000, maximum idle clk cycles between bytes inside a frame (1 ms at 16 MHz).
- DIV_WIDTH, 24, width of the step-rate divider.
- RATE_RESET, 20, reset value of the rate register.
- ERR_WIDTH, 8, width of the error counter.

Ports:
- clk  in  1  system clock (16 MHz).
- rst  in  1  synchronous, active-high reset.
- byte_in  in  8  byte from the SPI receiver; valid only when byte_valid=1.
- byte_valid  in  1  one-cycle pulse per received byte.
- led  out  1  sequenced LED drive.
- pattern  out  8  current pattern register.
- rate  out  5  current rate register.
- ctrl  out  2  current control register: bit0 enable, bit1 invert.
- busy  out  1  high while the parser is not in IDLE.
- frame_ok  out  1  one-cycle pulse when a frame is accepted.
- frame_err  out  1  one-cycle pulse when a frame is rejected or times out.
- err_count  out  ERR_WIDTH  saturating count of rejected frames.

Behaviour:
- Reset values: pattern=0x00, rate=RATE_RESET, ctrl=2'b01, led=0, busy=0, frame_ok=0, frame_err=0, err_count=0, parser in IDLE, divider=0, bit_idx=0.
- Asserting rst mid-frame discards the partial frame; no pulses are generated.
- Frame format: SYNC, ADDR, DATA, CHK, where CHK = SYNC ^ ADDR ^ DATA.
- Parser states: IDLE -> ADDR -> DATA -> CHECK -> IDLE. All transitions occur on byte_valid.
  - IDLE: a byte equal to SYNC moves to ADDR. Any other byte is ignored silently (no error).
  - ADDR: latch ADDR, go to DATA.
  - DATA: latch DATA, go to CHECK.
  - CHECK: evaluate the frame and always return to IDLE.
- Frame acceptance: the frame is accepted when CHK matches and ADDR <= 3.
  - ADDR 0: pattern <= DATA.
  - ADDR 1: rate <= min(DATA[4:0], DIV_WIDTH-1). DATA[7:5] is ignored.
  - ADDR 2: ctrl <= DATA[1:0].
  - ADDR 3: err_count <= 0. DATA is ignored.
- Accept timing: registers update and frame_ok pulses on the cycle after the CHK byte_valid.
- Frame rejection: a bad CHK or ADDR >= 4 pulses frame_err instead, at the same timing. Registers are unchanged; err_count increments and saturates at all-ones.
- Timeout counter:
  - Counts clk cycles while not in IDLE and byte_valid=0; clears on byte_valid and in IDLE.
  - When the count reaches TIMEOUT_CYCLES, the parser returns to IDLE, frame_err pulses and err_count increments.
  - If byte_valid coincides with the timeout cycle, the byte wins: it is processed and no timeout occurs.
- Timing: busy follows the registered state; there is no combinational path from byte_in to any output.
- LED sequencer, divider:
  - The divider counts every clk.
  - step_tick fires when divider == 2^rate - 1; on step_tick the divider clears.
  - rate=0 gives a tick every cycle.
- LED sequencer, bit index:
  - bit_idx (3 bits) increments on step_tick and wraps 7 -> 0.
  - An accepted write to ADDR 0 or 1 clears the divider and bit_idx on the same cycle the register updates, restarting the sequence.
- LED output:
  - led is registered: led = ctrl[0] ? (pattern[bit_idx] ^ ctrl[1]) : ctrl[1].
  - Output latency is 1 cycle after pattern, bit_idx or ctrl change.

Decomposition:
- Shared package spi_led_pkg:
  - Parser state enum (IDLE, ADDR, DATA, CHECK).
  - Register address constants: REG_PATTERN=0, REG_RATE=1, REG_CTRL=2, REG_CLRERR=3.
  - Control bit indices: CTRL_EN=0, CTRL_INV=1.
- One sub-module, led_pattern_seq: divider, bit_idx, registered led.
  - Inputs: clk, rst, pattern, rate, ctrl, restart.
  - Output: led.
- The parser and register file stay in the top of this block.

Test Plan:
- Reset check: after rst, with no bytes -> pattern=0x00, rate=20, ctrl=01, led=0, err_count=0, busy=0.
- Pattern and rate write: bytes A5 00 0F AA, then A5 01 02 A6 -> frame_ok twice, pattern=0x0F, rate=2; led high for 16 cycles then low for 16 cycles, repeating.
- Bad checksum and bad address: bytes A5 00 FF 00 -> frame_err, pattern unchanged, err_count=1. Bytes A5 05 00 A0 -> frame_err, err_count=2. Bytes A5 03 00 A6 -> frame_ok, err_count=0.
- Timeout: A5 00 then no bytes -> frame_err exactly TIMEOUT_CYCLES cycles after the last byte_valid; busy drops; the next A5 starts a fresh frame.
- Timeout race: byte_valid on the timeout cycle -> no frame_err, and the byte is processed.
- Noise, invert and reset: idle noise bytes 00 FF 12 -> no pulses, busy=0. A5 02 03 A4 -> led = ~pattern[bit_idx]. rst asserted after A5 00 -> parser in IDLE, registers at reset values.
